regfile_wb_scheduler: RTL and testbench

//  Owns the single regFile write port (we3/wr_addr3/wr_data3) in pipeline5.

---
 rtl/regfile_wb_scheduler_pkg.sv | 25 ++
 rtl/reg_scoreboard.sv | 49 ++++
 rtl/regfile_wb_scheduler.sv | 144 ++++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared core definitions used by the regFile writeback scheduler.
// Provides data/address widths, the word and register-address types, the
// write-port payload struct and a small x0 helper.
package regfile_wb_scheduler_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned REG_ADDR_W = $clog2(NUM_REGS);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xword_t;

  // One regFile write-port beat.
  typedef struct packed {
    logic      we;
    reg_addr_t addr;
    xword_t    data;
  } rf_wr_t;

  // True for any architectural register other than the hard-wired x0.
  function automatic logic addr_nz(input reg_addr_t a);
    return a != '0;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-register scoreboard for long-latency destinations.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   set_valid / set_addr    mark a register busy (issue)
//   clr_valid / clr_addr    mark a register free (result written)
//   look_a/b/c -> busy_a/b/c three registered-state lookups
//   busy_vec                full busy vector (bit 0 always 0)
module reg_scoreboard
  import regfile_wb_scheduler_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_valid,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_valid,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic [REG_ADDR_W-1:0] look_a,
  input  logic [REG_ADDR_W-1:0] look_b,
  input  logic [REG_ADDR_W-1:0] look_c,
  output logic                  busy_a,
  output logic                  busy_b,
  output logic                  busy_c,
  output logic [NUM_REGS-1:0]   busy_vec
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Clear first so that a same-cycle set of the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_valid) busy_d[clr_addr] = 1'b0;
    if (set_valid) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  always_comb begin
    busy_a   = busy_q[look_a];
    busy_b   = busy_q[look_b];
    busy_c   = busy_q[look_c];
    busy_vec = busy_q;
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Owner of the single regFile write port. Arbitrates between the in-order
// pipeline writeback (priority) and the long-latency unit writeback, tracks
// busy long-latency destinations, stalls decode on hazards against them and
// holds the pipeline writeback when the long-latency unit is starved.
// Ports:
//   pipe_we/addr/data        pipeline writeback (no backpressure)
//   mu_issue_valid/rd        long-latency issue, marks rd busy
//   mu_wb_valid/rd/data      long-latency result, mu_wb_ready accepts it
//   dec_rs1/rs2/rd           decode operands, dec_stall on busy hit
//   wb_hold                  registered request to stop pipe_we next cycle
//   rf_we3/wr_addr3/wr_data3 regFile write port (combinational grant)
//   err_conflict             sticky protocol-violation flag
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pipe_we,
  input  logic [REG_ADDR_W-1:0] pipe_addr,
  input  logic [XLEN-1:0]       pipe_data,
  input  logic                  mu_issue_valid,
  input  logic [REG_ADDR_W-1:0] mu_issue_rd,
  input  logic                  mu_wb_valid,
  input  logic [REG_ADDR_W-1:0] mu_wb_rd,
  input  logic [XLEN-1:0]       mu_wb_data,
  output logic                  mu_wb_ready,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  input  logic [REG_ADDR_W-1:0] dec_rd,
  output logic                  dec_stall,
  output logic                  wb_hold,
  output logic                  rf_we3,
  output logic [REG_ADDR_W-1:0] rf_wr_addr3,
  output logic [XLEN-1:0]       rf_wr_data3,
  output logic                  err_conflict
);

  localparam int unsigned     CNT_W    = $clog2(STARVE_LIMIT) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_TRIG = CNT_W'(STARVE_LIMIT - 1);

  logic                pipe_eff_c;
  logic                mu_xfer_c;
  logic                mu_refused_c;
  rf_wr_t              wr_c;

  logic                busy_rs1;
  logic                busy_rs2;
  logic                busy_rd;
  logic [NUM_REGS-1:0] busy_vec;

  logic [CNT_W-1:0]    starve_cnt_q;
  logic [CNT_W-1:0]    starve_cnt_d;
  logic                wb_hold_q;
  logic                wb_hold_d;
  logic                err_q;
  logic                err_d;

  // Port grant: pipeline first, then the long-latency result; x0 writes drop.
  // Everything combinational is forced quiet while reset is asserted.
  always_comb begin
    pipe_eff_c   = pipe_we & addr_nz(pipe_addr);
    mu_wb_ready  = rst_n & mu_wb_valid & ~pipe_eff_c;
    mu_xfer_c    = mu_wb_valid & mu_wb_ready;
    mu_refused_c = rst_n & mu_wb_valid & ~mu_wb_ready;
    wr_c         = '0;
    if (rst_n) begin
      if (pipe_eff_c) begin
        wr_c.we   = 1'b1;
        wr_c.addr = pipe_addr;
        wr_c.data = pipe_data;
      end else if (mu_wb_valid) begin
        wr_c.we   = addr_nz(mu_wb_rd);
        wr_c.addr = mu_wb_rd;
        wr_c.data = mu_wb_data;
      end
    end
    rf_we3      = wr_c.we;
    rf_wr_addr3 = wr_c.addr;
    rf_wr_data3 = wr_c.data;
  end

  reg_scoreboard u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_valid (mu_issue_valid & addr_nz(mu_issue_rd)),
    .set_addr  (mu_issue_rd),
    .clr_valid (mu_xfer_c),
    .clr_addr  (mu_wb_rd),
    .look_a    (dec_rs1),
    .look_b    (dec_rs2),
    .look_c    (dec_rd),
    .busy_a    (busy_rs1),
    .busy_b    (busy_rs2),
    .busy_c    (busy_rd),
    .busy_vec  (busy_vec)
  );

  // x0 never reads busy, so its lookup terms are inherently zero.
  always_comb begin
    dec_stall = rst_n & (busy_rs1 | busy_rs2 | busy_rd);
  end

  // Starvation tracking; hold drops once the pending result is gone.
  always_comb begin
    starve_cnt_d = '0;
    wb_hold_d    = wb_hold_q;
    if (mu_refused_c) begin
      starve_cnt_d = (starve_cnt_q == CNT_MAX) ? starve_cnt_q
                                               : starve_cnt_q + CNT_W'(1);
      if (starve_cnt_q >= CNT_TRIG) wb_hold_d = 1'b1;
    end else begin
      wb_hold_d = 1'b0;
    end
  end

  // Sticky protocol-violation detection.
  always_comb begin
    err_d = err_q
          | (pipe_eff_c & wb_hold_q)
          | (pipe_eff_c & busy_vec[pipe_addr])
          | (mu_issue_valid & busy_vec[mu_issue_rd]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      wb_hold_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      wb_hold_q    <= wb_hold_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    wb_hold      = wb_hold_q;
    err_conflict = err_q;
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: directed stimulus, a
// behavioural model compared every cycle, and literal spot checks.
module tb_regfile_wb_scheduler;
  import regfile_wb_scheduler_pkg::*;

  localparam int unsigned LIMIT = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  pipe_we;
  logic [REG_ADDR_W-1:0] pipe_addr;
  logic [XLEN-1:0]       pipe_data;
  logic                  mu_issue_valid;
  logic [REG_ADDR_W-1:0] mu_issue_rd;
  logic                  mu_wb_valid;
  logic [REG_ADDR_W-1:0] mu_wb_rd;
  logic [XLEN-1:0]       mu_wb_data;
  logic                  mu_wb_ready;
  logic [REG_ADDR_W-1:0] dec_rs1;
  logic [REG_ADDR_W-1:0] dec_rs2;
  logic [REG_ADDR_W-1:0] dec_rd;
  logic                  dec_stall;
  logic                  wb_hold;
  logic                  rf_we3;
  logic [REG_ADDR_W-1:0] rf_wr_addr3;
  logic [XLEN-1:0]       rf_wr_data3;
  logic                  err_conflict;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_wb_scheduler #(.STARVE_LIMIT(LIMIT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pipe_we        (pipe_we),
    .pipe_addr      (pipe_addr),
    .pipe_data      (pipe_data),
    .mu_issue_valid (mu_issue_valid),
    .mu_issue_rd    (mu_issue_rd),
    .mu_wb_valid    (mu_wb_valid),
    .mu_wb_rd       (mu_wb_rd),
    .mu_wb_data     (mu_wb_data),
    .mu_wb_ready    (mu_wb_ready),
    .dec_rs1        (dec_rs1),
    .dec_rs2        (dec_rs2),
    .dec_rd         (dec_rd),
    .dec_stall      (dec_stall),
    .wb_hold        (wb_hold),
    .rf_we3         (rf_we3),
    .rf_wr_addr3    (rf_wr_addr3),
    .rf_wr_data3    (rf_wr_data3),
    .err_conflict   (err_conflict)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model state: busy set, length of the current refusal streak, hold, error.
  logic [NUM_REGS-1:0] m_busy   = '0;
  int                  m_streak = 0;
  logic                m_hold   = 1'b0;
  logic                m_err    = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    logic [NUM_REGS-1:0] nb;
    logic pe, rdy, refused, ne;
    if (!rst_n) begin
      m_busy   <= '0;
      m_streak <= 0;
      m_hold   <= 1'b0;
      m_err    <= 1'b0;
    end else begin
      pe      = pipe_we && (pipe_addr != 0);
      rdy     = mu_wb_valid && !pe;
      refused = mu_wb_valid && !rdy;
      ne      = m_err;
      if (pe && (m_hold || m_busy[pipe_addr])) ne = 1'b1;
      if (mu_issue_valid && m_busy[mu_issue_rd]) ne = 1'b1;
      m_err <= ne;
      if (refused) begin
        // The LIMIT-th consecutive refusal raises the hold.
        if (m_streak + 1 >= LIMIT) m_hold <= 1'b1;
        m_streak <= m_streak + 1;
      end else begin
        m_streak <= 0;
        m_hold   <= 1'b0;
      end
      nb = m_busy;
      if (rdy) nb[mu_wb_rd] = 1'b0;
      if (mu_issue_valid && mu_issue_rd != 0) nb[mu_issue_rd] = 1'b1;
      m_busy <= nb;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin : compare
    logic pe, e_rdy, e_we, e_stall;
    pe      = pipe_we && (pipe_addr != 0);
    e_rdy   = rst_n && mu_wb_valid && !pe;
    e_we    = rst_n && (pe || (mu_wb_valid && mu_wb_rd != 0));
    e_stall = rst_n && (m_busy[dec_rs1] || m_busy[dec_rs2] || m_busy[dec_rd]);
    chk("m_ready", 64'(mu_wb_ready), 64'(e_rdy));
    chk("m_we",    64'(rf_we3),      64'(e_we));
    chk("m_stall", 64'(dec_stall),   64'(e_stall));
    chk("m_hold",  64'(wb_hold),     64'(m_hold));
    chk("m_err",   64'(err_conflict), 64'(m_err));
    if (e_we) begin
      chk("m_addr", 64'(rf_wr_addr3), pe ? 64'(pipe_addr) : 64'(mu_wb_rd));
      chk("m_data", 64'(rf_wr_data3), pe ? 64'(pipe_data) : 64'(mu_wb_data));
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic idle();
    pipe_we = 0; pipe_addr = 0; pipe_data = 0;
    mu_issue_valid = 0; mu_issue_rd = 0;
    mu_wb_valid = 0; mu_wb_rd = 0; mu_wb_data = 0;
    dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin : stim
    // Reset with every input driven high.
    rst_n = 1'b0;
    pipe_we = 1; pipe_addr = '1; pipe_data = '1;
    mu_issue_valid = 1; mu_issue_rd = '1;
    mu_wb_valid = 1; mu_wb_rd = '1; mu_wb_data = '1;
    dec_rs1 = '1; dec_rs2 = '1; dec_rd = '1;
    repeat (2) smp();
    chk("rst_we",    64'(rf_we3),       64'd0);
    chk("rst_ready", 64'(mu_wb_ready),  64'd0);
    chk("rst_stall", 64'(dec_stall),    64'd0);
    chk("rst_hold",  64'(wb_hold),      64'd0);
    chk("rst_err",   64'(err_conflict), 64'd0);
    nxt(); idle(); rst_n = 1'b1;
    smp();

    // Contention: pipeline wins, mu goes next cycle.
    nxt();
    pipe_we = 1; pipe_addr = 5; pipe_data = 32'hAAAA;
    mu_wb_valid = 1; mu_wb_rd = 7; mu_wb_data = 32'h1234;
    smp();
    chk("c2_we",    64'(rf_we3),      64'd1);
    chk("c2_addr",  64'(rf_wr_addr3), 64'd5);
    chk("c2_data",  64'(rf_wr_data3), 64'hAAAA);
    chk("c2_ready", 64'(mu_wb_ready), 64'd0);
    nxt(); pipe_we = 0;
    smp();
    chk("c2_mu_addr",  64'(rf_wr_addr3), 64'd7);
    chk("c2_mu_data",  64'(rf_wr_data3), 64'h1234);
    chk("c2_mu_ready", 64'(mu_wb_ready), 64'd1);
    nxt(); mu_wb_valid = 0;
    smp();

    // Scoreboard set, clear, and same-cycle set+clear.
    nxt(); mu_issue_valid = 1; mu_issue_rd = 9; dec_rs1 = 9;
    smp();
    chk("t3_stall_same", 64'(dec_stall), 64'd0);
    nxt(); mu_issue_valid = 0;
    smp();
    chk("t3_stall_busy", 64'(dec_stall), 64'd1);
    nxt(); mu_wb_valid = 1; mu_wb_rd = 9; mu_wb_data = 32'h99;
    smp();
    chk("t3_stall_xfer", 64'(dec_stall), 64'd1);
    nxt(); mu_wb_valid = 0;
    smp();
    chk("t3_stall_clear", 64'(dec_stall), 64'd0);
    nxt(); mu_issue_valid = 1; mu_issue_rd = 9; mu_wb_valid = 1; mu_wb_rd = 9; mu_wb_data = 32'h42;
    smp();
    chk("t3_both_ready", 64'(mu_wb_ready), 64'd1);
    nxt(); mu_issue_valid = 0; mu_wb_valid = 0;
    smp();
    chk("t3_set_wins", 64'(dec_stall), 64'd1);
    nxt(); mu_wb_valid = 1; mu_wb_rd = 9;
    smp();
    nxt(); mu_wb_valid = 0; dec_rs1 = 0;
    smp();
    chk("t3_err", 64'(err_conflict), 64'd0);

    // Starvation: four refused cycles, then hold.
    nxt();
    pipe_we = 1; pipe_addr = 4; pipe_data = 32'h400;
    mu_wb_valid = 1; mu_wb_rd = 6; mu_wb_data = 32'h55;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("t4_hold_pre", 64'(wb_hold), 64'd0);
      chk("t4_refused",  64'(mu_wb_ready), 64'd0);
      nxt();
    end
    pipe_we = 0;
    smp();
    chk("t4_hold",  64'(wb_hold),     64'd1);
    chk("t4_ready", 64'(mu_wb_ready), 64'd1);
    chk("t4_addr",  64'(rf_wr_addr3), 64'd6);
    nxt(); mu_wb_valid = 0;
    smp();
    chk("t4_hold_clear", 64'(wb_hold), 64'd0);
    chk("t4_err",        64'(err_conflict), 64'd0);

    // x0 handling and the sticky error.
    nxt();
    pipe_we = 1; pipe_addr = 0; pipe_data = 32'hDEAD;
    mu_wb_valid = 1; mu_wb_rd = 8; mu_wb_data = 32'h77;
    smp();
    chk("t5_x0_ready", 64'(mu_wb_ready), 64'd1);
    chk("t5_x0_addr",  64'(rf_wr_addr3), 64'd8);
    chk("t5_x0_data",  64'(rf_wr_data3), 64'h77);
    nxt(); pipe_we = 0; mu_wb_rd = 0; mu_wb_data = 32'h88;
    smp();
    chk("t5_mu0_ready", 64'(mu_wb_ready), 64'd1);
    chk("t5_mu0_we",    64'(rf_we3),      64'd0);
    nxt(); pipe_we = 1; pipe_addr = 4; mu_wb_rd = 8;
    for (int i = 0; i < 4; i++) begin
      smp();
      nxt();
    end
    smp();
    chk("t5_hold",    64'(wb_hold),      64'd1);
    chk("t5_err_pre", 64'(err_conflict), 64'd0);
    nxt(); pipe_we = 0;
    smp();
    chk("t5_err_set", 64'(err_conflict), 64'd1);
    nxt(); mu_wb_valid = 0;
    repeat (3) nxt();
    smp();
    chk("t5_err_sticky", 64'(err_conflict), 64'd1);

    // Async reset mid-hold with x3 busy.
    nxt(); idle(); mu_issue_valid = 1; mu_issue_rd = 3; dec_rs2 = 3;
    smp();
    nxt(); mu_issue_valid = 0;
    pipe_we = 1; pipe_addr = 4; pipe_data = 32'h4;
    mu_wb_valid = 1; mu_wb_rd = 10; mu_wb_data = 32'hA0A0;
    for (int i = 0; i < 4; i++) begin
      smp();
      nxt();
    end
    smp();
    chk("t6_hold_pre",  64'(wb_hold),   64'd1);
    chk("t6_stall_pre", 64'(dec_stall), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_hold",  64'(wb_hold),      64'd0);
    chk("t6_rst_stall", 64'(dec_stall),    64'd0);
    chk("t6_rst_err",   64'(err_conflict), 64'd0);
    chk("t6_rst_we",    64'(rf_we3),       64'd0);
    nxt(); rst_n = 1'b1; pipe_we = 0;
    smp();
    chk("t6_post_ready", 64'(mu_wb_ready), 64'd1);
    chk("t6_post_we",    64'(rf_we3),      64'd1);
    chk("t6_post_addr",  64'(rf_wr_addr3), 64'd10);
    chk("t6_post_data",  64'(rf_wr_data3), 64'hA0A0);
    chk("t6_post_stall", 64'(dec_stall),   64'd0);
    nxt(); idle();
    smp();
    chk("t6_post_hold", 64'(wb_hold), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
